// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM model's handshake state and the memory
// arbiter's grant state.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants issued while a fetch waits and flags when the
// next arbitration must go to the fetch. STARVE_LIMIT of 0 never forces.
module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic enter_d,
    input  logic enter_i,
    input  logic ireq,
    output logic forced
);

    localparam int unsigned W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(STARVE_LIMIT);

    logic [W-1:0] dstreak;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (enter_i) begin
            dstreak <= '0;
        end else if (enter_d && ireq && (dstreak != LIMIT)) begin
            dstreak <= dstreak + 1'b1;
        end
    end

    assign forced = (STARVE_LIMIT != 0) && (dstreak == LIMIT) && ireq;

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access, data
// first with bounded fetch starvation. Define MEM_ARB_PERF_EN for perf counters.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] conflict_cycles
`endif
);

    arb_state_t state, next_state;
    logic       dreq;
    logic       forced;
    logic       done;

    assign dreq = dREN || dWEN;
    // ERROR also ends the grant; the request is simply re-arbitrated.
    assign done = (ramstate == ACCESS) || (ramstate == ERROR);

    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .CLK     (CLK),
        .nRST    (nRST),
        .enter_d ((state == IDLE) && (next_state == GRANT_D)),
        .enter_i ((state == IDLE) && (next_state == GRANT_I)),
        .ireq    (iREN),
        .forced  (forced)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        unique case (state)
            IDLE: begin
                if (dreq && !forced) next_state = GRANT_D;
                else if (iREN)       next_state = GRANT_I;
            end
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = (ramstate != ACCESS);
                if (!iREN || done) next_state = IDLE;
            end
            GRANT_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = (ramstate != ACCESS);
                if (!dreq || done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount          <= '0;
            dcount          <= '0;
            conflict_cycles <= '0;
        end else begin
            if ((state == GRANT_I) && (ramstate == ACCESS)) icount <= icount + 32'd1;
            if ((state == GRANT_D) && (ramstate == ACCESS)) dcount <= dcount + 32'd1;
            if (iREN && dreq) conflict_cycles <= conflict_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// corner sequences, and random traffic against an ownership-level model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t   ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] icount, dcount, conflict_cycles;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_PERF_EN
        , .icount(icount), .dcount(dcount), .conflict_cycles(conflict_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input ramstate_t rs,
                         input logic [31:0] rl);
        iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
    endtask

    task automatic check_all(input string tag, input logic e_ren, input logic e_wen,
                             input logic [31:0] e_addr, input logic [31:0] e_store,
                             input logic e_iwait, input logic e_dwait);
        check_bit({tag, ".ramREN"}, ramREN, e_ren);
        check_bit({tag, ".ramWEN"}, ramWEN, e_wen);
        check({tag, ".ramaddr"}, ramaddr, e_addr);
        check({tag, ".ramstore"}, ramstore, e_store);
        check_bit({tag, ".iwait"}, iwait, e_iwait);
        check_bit({tag, ".dwait"}, dwait, e_dwait);
        check({tag, ".iload"}, iload, ramload);
        check({tag, ".dload"}, dload, ramload);
    endtask

    // Holds the bench in reset across one rising edge, releases on a falling edge.
    task automatic do_reset();
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, FREE, '0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da, ds;
        ramstate_t   rs;
        logic [31:0] rl;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait;
    } vec_t;

    function automatic vec_t mkv(logic ir, logic dr, logic dw, logic [31:0] ia,
                                 logic [31:0] da, logic [31:0] ds, ramstate_t rs,
                                 logic [31:0] rl, logic e_ren, logic e_wen,
                                 logic [31:0] e_addr, logic [31:0] e_store,
                                 logic e_iwait, logic e_dwait);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
        v.rs = rs; v.rl = rl; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_addr = e_addr; v.e_store = e_store; v.e_iwait = e_iwait; v.e_dwait = e_dwait;
        return v;
    endfunction

    // Reference model: who owns the RAM port and data grants since the last fetch grant.
    int owner = 0;  // 0 none, 1 fetch, 2 data
    int streak = 0;

    task automatic model_step();
        bit dq;
        dq = dREN || dWEN;
        if (owner == 0) begin
            if (dq && !(LIMIT != 0 && streak == LIMIT && iREN)) begin
                owner = 2;
                if (iREN) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
            end else if (iREN) begin
                owner = 1;
                streak = 0;
            end
        end else if (owner == 1) begin
            if (!iREN || ramstate == ACCESS || ramstate == ERROR) owner = 0;
        end else begin
            if (!dq || ramstate == ACCESS || ramstate == ERROR) owner = 0;
        end
    endtask

    vec_t vecs[12];
    byte  grants[$];
    string exp_order;

    initial begin
        // Reset with a fetch already requested: nothing reaches the RAM.
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h40, '0, '0, ACCESS, 32'h55);
        #1;
        check_all("reset", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;

        vecs[0]  = mkv(1,0,0, 32'h40, 0, 0, FREE, 32'h0, 0,0, 32'h0, 32'h0, 1,1);
        vecs[1]  = mkv(1,0,0, 32'h40, 0, 0, ACCESS, 32'h1234, 1,0, 32'h40, 32'h0, 0,1);
        vecs[2]  = mkv(1,1,0, 32'h40, 32'h100, 0, FREE, 32'h0, 0,0, 32'h0, 32'h0, 1,1);
        vecs[3]  = mkv(1,1,0, 32'h40, 32'h100, 0, ACCESS, 32'hA5A5, 1,0, 32'h100, 32'h0, 1,0);
        vecs[4]  = mkv(1,0,0, 32'h40, 32'h100, 0, FREE, 32'h0, 0,0, 32'h0, 32'h0, 1,1);
        vecs[5]  = mkv(1,0,0, 32'h44, 0, 0, ACCESS, 32'h77, 1,0, 32'h44, 32'h0, 0,1);
        vecs[6]  = mkv(0,0,1, 0, 32'h200, 32'hDEADBEEF, FREE, 32'h0, 0,0, 32'h0, 32'h0, 1,1);
        vecs[7]  = mkv(0,0,1, 0, 32'h200, 32'hDEADBEEF, BUSY, 32'h0, 0,1, 32'h200, 32'hDEADBEEF, 1,1);
        vecs[8]  = mkv(0,0,1, 0, 32'h200, 32'hDEADBEEF, BUSY, 32'h0, 0,1, 32'h200, 32'hDEADBEEF, 1,1);
        vecs[9]  = mkv(0,0,1, 0, 32'h200, 32'hDEADBEEF, BUSY, 32'h0, 0,1, 32'h200, 32'hDEADBEEF, 1,1);
        vecs[10] = mkv(0,0,1, 0, 32'h200, 32'hDEADBEEF, ACCESS, 32'h0, 0,1, 32'h200, 32'hDEADBEEF, 1,0);
        vecs[11] = mkv(0,0,0, 0, 0, 0, FREE, 32'h0, 0,0, 32'h0, 32'h0, 1,1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da,
                  vecs[i].ds, vecs[i].rs, vecs[i].rl);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_ren, vecs[i].e_wen,
                      vecs[i].e_addr, vecs[i].e_store, vecs[i].e_iwait, vecs[i].e_dwait);
            @(negedge CLK);
        end

        // Starvation bound: both requesters always pending, RAM always ready.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h100, '0, ACCESS, '0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ramREN) grants.push_back((ramaddr == 32'h100) ? "D" : "I");
            @(negedge CLK);
        end
        exp_order = "DDDDIDDDDI";
        check("starve.grants", grants.size(), 10);
        for (int g = 0; g < 10 && g < grants.size(); g++)
            check($sformatf("starve.grant%0d", g), grants[g], exp_order[g]);

        // ERROR during a fetch: wait stays high, idle cycle, then retried.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h80, '0, '0, FREE, '0);
        @(negedge CLK);
        ramstate = ERROR; #1;
        check_bit("err.ramREN", ramREN, 1'b1);
        check_bit("err.iwait", iwait, 1'b1);
        @(negedge CLK);
        ramstate = FREE; #1;
        check_bit("err.idle_ramREN", ramREN, 1'b0);
        @(negedge CLK);
        ramstate = ACCESS; #1;
        check_bit("err.retry_ramREN", ramREN, 1'b1);
        check("err.retry_addr", ramaddr, 32'h80);
        check_bit("err.retry_iwait", iwait, 1'b0);
        @(negedge CLK);

        // Data requester drops its request mid-grant: enables fall at once.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, '0, 32'h300, '0, FREE, '0);
        @(negedge CLK); #1;
        check_bit("abort.granted", ramREN, 1'b1);
        dREN = 1'b0; #1;
        check_bit("abort.ramREN", ramREN, 1'b0);
        check_bit("abort.dwait", dwait, 1'b1);
        @(negedge CLK);
        dREN = 1'b1; #1;
        check_bit("abort.idle", ramREN, 1'b0);
        @(negedge CLK);

        // Reset asserted in the middle of a write grant.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, '0, 32'h400, 32'hCAFE, BUSY, '0);
        @(negedge CLK); #1;
        check_bit("rstmid.ramWEN_before", ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check_bit("rstmid.ramWEN", ramWEN, 1'b0);
        check("rstmid.ramaddr", ramaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic against the ownership model.
        do_reset();
        owner = 0;
        streak = 0;
        for (int c = 0; c < 400; c++) begin
            iREN = (iREN && ($urandom_range(7) != 0)) || ($urandom_range(2) == 0);
            if (!(dREN || dWEN) || ($urandom_range(7) == 0)) begin
                case ($urandom_range(3))
                    0:       begin dREN = 1'b1; dWEN = 1'b0; end
                    1:       begin dREN = 1'b0; dWEN = 1'b1; end
                    default: begin dREN = 1'b0; dWEN = 1'b0; end
                endcase
            end
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = ramstate_t'($urandom_range(3));
            #1;
            case (owner)
                1:       check_all("rand", iREN, 1'b0, iaddr, 32'h0, ramstate != ACCESS, 1'b1);
                2:       check_all("rand", dREN, dWEN, daddr, dstore, 1'b1, ramstate != ACCESS);
                default: check_all("rand", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            endcase
            model_step();
            @(negedge CLK);
        end

`ifdef MEM_ARB_PERF_EN
        // Three fetches, two data accesses, five overlap cycles.
        do_reset();
        ramstate = ACCESS;
        for (int c = 0; c < 11; c++) begin
            iREN = (c <= 9);
            dREN = (c >= 1 && c <= 5);
            @(negedge CLK);
        end
        check("perf.icount", icount, 32'd3);
        check("perf.dcount", dcount, 32'd2);
        check("perf.conflict_cycles", conflict_cycles, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
